// File: rtl/vx_dp_ram_if.sv
// Bus bundle for vx_dp_ram: write/read ports, entry release, free-entry tracking.
// The release strobe is rel because release is a reserved word.
interface vx_dp_ram_if #(
    parameter int DATAW   = 1,
    parameter int SIZE    = 1,
    parameter int BYTEENW = 1,
    parameter int ADDRW   = (SIZE > 1) ? $clog2(SIZE) : 1
);
    logic [ADDRW-1:0]   waddr;
    logic               wren;
    logic [BYTEENW-1:0] byteen;
    logic [DATAW-1:0]   din;
    logic [ADDRW-1:0]   raddr;
    logic               rden;
    logic [DATAW-1:0]   dout;
    logic               rel;
    logic [ADDRW-1:0]   release_addr;
    logic [ADDRW-1:0]   free_index;
    logic [SIZE-1:0]    free_onehot;
    logic               free_valid;
    logic               full;

    modport master (
        output waddr, wren, byteen, din, raddr, rden, rel, release_addr,
        input  dout, free_index, free_onehot, free_valid, full
    );

    modport slave (
        input  waddr, wren, byteen, din, raddr, rden, rel, release_addr,
        output dout, free_index, free_onehot, free_valid, full
    );
endinterface

// File: rtl/vx_dp_ram.sv
// Dual-port RAM with per-lane write enables and an occupancy tracker that
// reports the lowest-numbered free entry.
module vx_dp_ram #(
    parameter int DATAW   = 1,
    parameter int SIZE    = 1,
    parameter int BYTEENW = 1,
    parameter int RWCHECK = 1,
    parameter int FASTRAM = 1,
    parameter int ADDRW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic       clk,
    input  logic       reset,
    vx_dp_ram_if.slave bus
);
    localparam int LANEW = DATAW / BYTEENW;
    localparam logic [ADDRW:0] SIZE_W = (ADDRW+1)'(SIZE);

    logic [DATAW-1:0] r_mem [SIZE];
    logic [SIZE-1:0]  r_occ;

    logic             w_wr_ok;
    logic             w_rel_ok;
    logic             w_rd_ok;
    logic             w_bypass;
    logic [DATAW-1:0] w_mem_rd;
    logic [DATAW-1:0] w_rd_data;
    logic [ADDRW-1:0] w_free_idx;
    logic [SIZE-1:0]  w_free_oh;

    // Addresses past SIZE exist only when SIZE is not a power of two; drop them.
    assign w_wr_ok  = bus.wren && ({1'b0, bus.waddr} < SIZE_W);
    assign w_rel_ok = bus.rel  && ({1'b0, bus.release_addr} < SIZE_W);
    assign w_rd_ok  = {1'b0, bus.raddr} < SIZE_W;

    // Data array carries no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int i = 0; i < BYTEENW; i++) begin
                if (bus.byteen[i])
                    r_mem[bus.waddr][i*LANEW +: LANEW] <= bus.din[i*LANEW +: LANEW];
            end
        end
    end

    // Write is ordered after release so a same-address collision stays occupied.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_occ <= '0;
        end else begin
            if (w_rel_ok) r_occ[bus.release_addr] <= 1'b0;
            if (w_wr_ok)  r_occ[bus.waddr]        <= 1'b1;
        end
    end

    assign w_mem_rd = w_rd_ok ? r_mem[bus.raddr] : '0;
    assign w_bypass = (RWCHECK != 0) && w_wr_ok && w_rd_ok && (bus.raddr == bus.waddr);

    always_comb begin
        w_rd_data = w_mem_rd;
        for (int i = 0; i < BYTEENW; i++) begin
            if (w_bypass && bus.byteen[i])
                w_rd_data[i*LANEW +: LANEW] = bus.din[i*LANEW +: LANEW];
        end
    end

    if (FASTRAM != 0) begin : g_fast
        assign bus.dout = w_rd_data;
    end else begin : g_slow
        logic [DATAW-1:0] r_dout;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)        r_dout <= '0;
            else if (bus.rden) r_dout <= w_rd_data;
        end
        assign bus.dout = r_dout;
    end

    // Scan high to low so the lowest free entry is the last one written.
    always_comb begin
        w_free_idx = '0;
        w_free_oh  = '0;
        for (int i = SIZE-1; i >= 0; i--) begin
            if (!r_occ[i]) begin
                w_free_idx = ADDRW'(i);
                w_free_oh  = SIZE'(1) << i;
            end
        end
    end

    assign bus.free_index  = w_free_idx;
    assign bus.free_onehot = w_free_oh;
    assign bus.free_valid  = ~&r_occ;
    assign bus.full        = &r_occ;
endmodule

// File: tb/tb_vx_dp_ram.sv
// Directed checks of vx_dp_ram across fast/registered read, RWCHECK modes,
// byte lanes, occupancy tracking and non-power-of-two sizing.
module tb_vx_dp_ram;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a: 32-bit, 4 lanes, fast read; b/c: registered read, RWCHECK 1/0; d: SIZE=5
    vx_dp_ram_if #(.DATAW(32), .SIZE(4), .BYTEENW(4)) ia ();
    vx_dp_ram_if #(.DATAW(8),  .SIZE(4), .BYTEENW(1)) ib ();
    vx_dp_ram_if #(.DATAW(8),  .SIZE(4), .BYTEENW(1)) ic ();
    vx_dp_ram_if #(.DATAW(8),  .SIZE(5), .BYTEENW(1)) id ();

    vx_dp_ram #(.DATAW(32), .SIZE(4), .BYTEENW(4), .RWCHECK(1), .FASTRAM(1))
        u_a (.clk(clk), .reset(reset), .bus(ia.slave));
    vx_dp_ram #(.DATAW(8), .SIZE(4), .BYTEENW(1), .RWCHECK(1), .FASTRAM(0))
        u_b (.clk(clk), .reset(reset), .bus(ib.slave));
    vx_dp_ram #(.DATAW(8), .SIZE(4), .BYTEENW(1), .RWCHECK(0), .FASTRAM(0))
        u_c (.clk(clk), .reset(reset), .bus(ic.slave));
    vx_dp_ram #(.DATAW(8), .SIZE(5), .BYTEENW(1), .RWCHECK(1), .FASTRAM(1))
        u_d (.clk(clk), .reset(reset), .bus(id.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ia.wren = 0; ia.rel = 0; ia.rden = 0;
        ib.wren = 0; ib.rel = 0; ib.rden = 0;
        ic.wren = 0; ic.rel = 0; ic.rden = 0;
        id.wren = 0; id.rel = 0; id.rden = 0;
    endtask

    task automatic bc_drive(input logic wr, input logic [1:0] wa, input logic [7:0] d,
                            input logic rd, input logic [1:0] ra);
        ib.wren = wr; ib.waddr = wa; ib.din = d; ib.byteen = 1'b1; ib.rden = rd; ib.raddr = ra;
        ic.wren = wr; ic.waddr = wa; ic.din = d; ic.byteen = 1'b1; ic.rden = rd; ic.raddr = ra;
    endtask

    initial begin
        reset = 1'b0;
        ia.waddr = '0; ia.byteen = '0; ia.din = '0; ia.raddr = '0; ia.release_addr = '0;
        ib.waddr = '0; ib.byteen = '0; ib.din = '0; ib.raddr = '0; ib.release_addr = '0;
        ic.waddr = '0; ic.byteen = '0; ic.din = '0; ic.raddr = '0; ic.release_addr = '0;
        id.waddr = '0; id.byteen = '0; id.din = '0; id.raddr = '0; id.release_addr = '0;
        idle_all();
        tick(); tick();

        // ---- reset state ----
        chk("rst_free_index", 64'(ia.free_index), 64'd0);
        chk("rst_free_onehot", 64'(ia.free_onehot), 64'h1);
        chk("rst_free_valid", 64'(ia.free_valid), 64'd1);
        chk("rst_full", 64'(ia.full), 64'd0);
        chk("rst_dout_b", 64'(ib.dout), 64'd0);
        chk("rst_dout_c", 64'(ic.dout), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ---- fill a: writes 0..3 ----
        for (int k = 0; k < 4; k++) begin
            ia.wren = 1; ia.waddr = 2'(k); ia.din = 32'hA0 + 32'(k); ia.byteen = 4'hF;
            tick();
            ia.wren = 0;
            if (k < 3) begin
                chk("fill_free_index", 64'(ia.free_index), 64'(k + 1));
                chk("fill_full", 64'(ia.full), 64'd0);
            end
        end
        chk("full_full", 64'(ia.full), 64'd1);
        chk("full_free_valid", 64'(ia.free_valid), 64'd0);
        chk("full_free_onehot", 64'(ia.free_onehot), 64'd0);
        chk("full_free_index", 64'(ia.free_index), 64'd0);
        ia.raddr = 2'd2; #1;
        chk("read2", 64'(ia.dout), 64'hA2);

        // ---- release 2, then write+release on same addr 1 ----
        ia.rel = 1; ia.release_addr = 2'd2;
        tick(); ia.rel = 0;
        chk("rel2_free_index", 64'(ia.free_index), 64'd2);
        chk("rel2_full", 64'(ia.full), 64'd0);
        ia.wren = 1; ia.waddr = 2'd1; ia.din = 32'hB1; ia.rel = 1; ia.release_addr = 2'd1;
        tick(); ia.wren = 0; ia.rel = 0;
        chk("wr_rel_same_idx", 64'(ia.free_index), 64'd2);
        // different addresses: write 2, release 3 -> only 3 free (1 must still be occupied)
        ia.wren = 1; ia.waddr = 2'd2; ia.din = 32'hC2; ia.rel = 1; ia.release_addr = 2'd3;
        tick(); ia.wren = 0; ia.rel = 0;
        chk("wr_rel_diff_idx", 64'(ia.free_index), 64'd3);
        chk("wr_rel_diff_oh", 64'(ia.free_onehot), 64'h8);
        ia.raddr = 2'd1; #1;
        chk("read1_after_wr", 64'(ia.dout), 64'hB1);
        // release of already-free entry
        ia.rel = 1; ia.release_addr = 2'd3;
        tick(); ia.rel = 0;
        chk("rel_free_noop", 64'(ia.free_index), 64'd3);

        // ---- byte lanes on a (writes to occupied entry 0) ----
        ia.wren = 1; ia.waddr = 2'd0; ia.din = 32'h11223344; ia.byteen = 4'hF;
        tick();
        ia.din = 32'hAABBCCDD; ia.byteen = 4'b0101;
        tick(); ia.wren = 0;
        ia.raddr = 2'd0; #1;
        chk("byteen_0101", 64'(ia.dout), 64'h11BB33DD);
        chk("ovwr_occ_idx", 64'(ia.free_index), 64'd3);
        // combinational bypass with masked lanes
        ia.wren = 1; ia.waddr = 2'd0; ia.din = 32'h12345678; ia.byteen = 4'b0011; #1;
        chk("fast_bypass", 64'(ia.dout), 64'h11BB5678);
        tick(); ia.wren = 0; #1;
        chk("fast_after_wr", 64'(ia.dout), 64'h11BB5678);

        // ---- registered read, RWCHECK 1 (b) vs 0 (c) ----
        bc_drive(1, 2'd3, 8'h05, 0, 2'd0);
        tick();
        chk("slow_hold_b", 64'(ib.dout), 64'd0);
        bc_drive(1, 2'd3, 8'h09, 1, 2'd3);
        tick();
        bc_drive(0, 2'd0, 8'h00, 0, 2'd0);
        chk("slow_rw_new_b", 64'(ib.dout), 64'h09);
        chk("slow_rw_old_c", 64'(ic.dout), 64'h05);
        tick();
        chk("slow_rden0_hold_c", 64'(ic.dout), 64'h05);
        bc_drive(0, 2'd0, 8'h00, 1, 2'd3);
        tick();
        bc_drive(0, 2'd0, 8'h00, 0, 2'd0);
        chk("slow_reread_c", 64'(ic.dout), 64'h09);

        // ---- SIZE=5: out-of-range addresses ----
        id.wren = 1; id.waddr = 3'd6; id.din = 8'h77; id.byteen = 1'b1;
        tick(); id.wren = 0;
        chk("oor_wr_idx", 64'(id.free_index), 64'd0);
        id.raddr = 3'd6; #1;
        chk("oor_rd", 64'(id.dout), 64'd0);
        for (int k = 0; k < 5; k++) begin
            id.wren = 1; id.waddr = 3'(k); id.din = 8'h50 + 8'(k);
            tick();
        end
        id.wren = 0;
        chk("d_full", 64'(id.full), 64'd1);
        id.rel = 1; id.release_addr = 3'd7;
        tick(); id.rel = 0;
        chk("oor_rel_full", 64'(id.full), 64'd1);
        id.wren = 1; id.waddr = 3'd5; id.din = 8'hEE; id.raddr = 3'd5; #1;
        chk("oor_bypass", 64'(id.dout), 64'd0);
        id.wren = 0;
        id.raddr = 3'd4; #1;
        chk("d_read4", 64'(id.dout), 64'h54);
        id.rel = 1; id.release_addr = 3'd4;
        tick(); id.rel = 0;
        chk("d_rel4_idx", 64'(id.free_index), 64'd4);

        // ---- asynchronous reset mid-cycle, a has entries 0..2 occupied ----
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_idx", 64'(ia.free_index), 64'd0);
        chk("async_rst_full", 64'(ia.full), 64'd0);
        chk("async_rst_oh", 64'(ia.free_onehot), 64'h1);
        chk("async_rst_dout_b", 64'(ib.dout), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vx_dp_ram.md
VX_DP_RAM -- requirements
Module: vx_dp_ram

Interface
REQ-001 Parameter DATAW, default 1, width of each data word in bits.
REQ-002 Parameter SIZE, default 1, number of entries; any value >= 1, power of two not required.
REQ-003 Parameter BYTEENW, default 1, write-enable lanes; DATAW divisible by BYTEENW, lane i covers bits [i*DATAW/BYTEENW +: DATAW/BYTEENW].
REQ-004 Parameter RWCHECK, default 1, 1 = same-address read during write returns new data; 0 = returns old data.
REQ-005 Parameter FASTRAM, default 1, 1 = combinational read; 0 = registered read with 1-cycle latency.
REQ-006 Parameter ADDRW, default LOG2UP(SIZE), address width (minimum 1).
REQ-007 Clocking: one clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  sole clock, all state updates on its rising edge.
REQ-009 reset  input  1  asynchronous active-low reset, asserted at 0.
REQ-010 waddr  input  ADDRW  write address.
REQ-011 wren  input  1  write strobe; also marks entry waddr occupied.
REQ-012 byteen  input  BYTEENW  per-lane write mask, qualified by wren.
REQ-013 din  input  DATAW  write data.
REQ-014 raddr  input  ADDRW  read address.
REQ-015 rden  input  1  read enable; matters only when FASTRAM=0.
REQ-016 dout  output  DATAW  read data.
REQ-017 release  input  1  marks entry release_addr free.
REQ-018 release_addr  input  ADDRW  entry to free.
REQ-019 free_index  output  ADDRW  lowest-numbered free entry.
REQ-020 free_onehot  output  SIZE  one-hot of free_index.
REQ-021 free_valid  output  1  at least one free entry exists.
REQ-022 full  output  1  equals ~free_valid.

Function
REQ-023 Write: on clk rise with wren=1, for each lane i with byteen[i]=1, mem[waddr] lane i takes din lane i; other lanes unchanged.
REQ-024 FASTRAM=1: dout = mem[raddr] combinationally; rden ignored.
REQ-025 FASTRAM=0: on clk rise with rden=1, dout register loads mem[raddr]; with rden=0 dout holds.
REQ-026 RWCHECK=1 with wren=1 and raddr==waddr: read returns din on enabled lanes, old contents on masked lanes (combinational bypass for FASTRAM=1, registered for FASTRAM=0).
REQ-027 RWCHECK=0 with same collision: read returns pre-write contents.
REQ-028 Occupancy vector occ[SIZE-1:0], registered: wren sets occ[waddr], release clears occ[release_addr].
REQ-029 Simultaneous wren and release on same address: entry ends occupied (write wins); on different addresses both apply.
REQ-030 free_onehot/free_index/free_valid: combinational priority encode of ~occ (current registered state), lowest index wins.
REQ-031 No free entry: free_valid=0, free_index=0, free_onehot=0, full=1.
REQ-032 Write to occupied entry is legal; data overwritten, occ stays 1.
REQ-033 Release of already-free entry is legal, no effect.
REQ-034 Addresses >= SIZE (non-power-of-two SIZE) ignored for writes, occupancy, and release; reads of them return 0.

Reset
REQ-035 reset=0 asynchronously clears occ to all 0: free_valid=1, free_index=0, free_onehot=1, full=0.
REQ-036 reset=0 clears FASTRAM=0 dout register to 0; memory contents not reset.
REQ-037 wren, release, rden ignored while reset=0; state valid first rising edge after deassertion.
REQ-038 Reset mid-operation: any in-flight write on the asserting edge discarded for occupancy; memory word may be lost.

Verification
REQ-039 SIZE=4, after reset -> free_index=0, free_onehot=4'b0001, free_valid=1, full=0.
REQ-040 SIZE=4, write addresses 0,1,2,3 (din=0xA0..0xA3) -> free_index 1,2,3 then full=1, free_valid=0, free_onehot=0; read 2 returns 0xA2.
REQ-041 Full SIZE=4, release 2 -> next cycle free_index=2, full=0; same-cycle wren=1 waddr=1 plus release 1 -> entry 1 remains occupied.
REQ-042 DATAW=32, BYTEENW=4, mem[0]=0x11223344, write din=0xAABBCCDD byteen=4'b0101 -> mem[0]=0x11BB33DD.
REQ-043 FASTRAM=0, RWCHECK=1, mem[3]=0x5, wren=1 waddr=3 din=0x9, rden=1 raddr=3 -> dout=0x9 next cycle; RWCHECK=0 -> 0x5.
REQ-044 Assert reset=0 mid-cycle with 3 entries occupied -> outputs immediately (no clock) free_index=0, full=0.
